// File: rtl/iterative_divider_if.sv
// Request/result bundle between the control unit and the iterative divider.
// The control unit (master) presents operands and start; the divider (slave)
// returns busy, the done pulse and the registered results.
interface iterative_divider_if #(
  parameter int width = 32
);
  logic             start;
  logic [width-1:0] dividend;
  logic [width-1:0] divisor;
  logic             busy;
  logic             done;
  logic [width-1:0] quotient;
  logic [width-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Radix-2 restoring shift-subtract unsigned divider, one quotient bit per
// clock. An accepted request runs for width RUN edges and reports the result
// through a one-cycle done pulse; a zero divisor short-cuts straight to DONE
// with quotient all ones and remainder equal to the dividend. All outputs
// come straight from flops.
module iterative_divider #(
  parameter int width = 32
) (
  input logic               clk,
  input logic               rst_n,
  iterative_divider_if.slave div_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Step counter runs 0..width-1; one extra bit keeps width a power of two safe.
  localparam int              CW       = $clog2(width) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(width - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] prem_q, prem_d;      // partial remainder R
  logic [width-1:0] pquo_q, pquo_d;      // dividend shifting out / quotient shifting in
  logic [width-1:0] dvsr_q, dvsr_d;      // divisor latched at accept
  logic [width-1:0] quotient_q, quotient_d;
  logic [width-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [width:0]   trial_s;             // {R, next dividend bit}, width+1 bits
  logic [width:0]   diff_s;              // trial minus divisor, width+1 bits
  logic             fits_s;              // trial >= divisor
  logic [width-1:0] prem_step_s;
  logic [width-1:0] pquo_step_s;
  logic             accept_s;

  // One restoring step. R < divisor holds on entry, so trial < 2*divisor and a
  // non-negative difference never reaches bit width; the top bit of the
  // width+1 difference is therefore exactly the borrow, i.e. trial < divisor.
  always_comb begin
    trial_s     = {prem_q, pquo_q[width-1]};
    diff_s      = trial_s - {1'b0, dvsr_q};
    fits_s      = ~diff_s[width];
    prem_step_s = fits_s ? diff_s[width-1:0] : trial_s[width-1:0];
    pquo_step_s = {pquo_q[width-2:0], fits_s};
  end

  // A request is taken only when no division is in progress.
  always_comb begin
    accept_s = div_if.start && (state_q != S_RUN);
  end

  // Next-state, datapath load and result capture for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    prem_d      = prem_q;
    pquo_d      = pquo_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (div_if.divisor == {width{1'b0}}) begin
            // Divide by zero resolves at the accept edge without iterating.
            state_d     = S_DONE;
            quotient_d  = {width{1'b1}};
            remainder_d = div_if.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
            count_d = {CW{1'b0}};
            prem_d  = {width{1'b0}};
            pquo_d  = div_if.dividend;
            dvsr_d  = div_if.divisor;
          end
        end else if (state_q == S_DONE) begin
          // The result pulse lasts one cycle only.
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        prem_d  = prem_step_s;
        pquo_d  = pquo_step_s;
        count_d = count_q + CW'(1);
        if (count_q == LAST_CNT) begin
          // Final bit: publish the result together with the done pulse.
          state_d     = S_DONE;
          quotient_d  = pquo_step_s;
          remainder_d = prem_step_s;
          dbz_d       = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers; reset discards any in-flight division.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= {CW{1'b0}};
      prem_q      <= {width{1'b0}};
      pquo_q      <= {width{1'b0}};
      dvsr_q      <= {width{1'b0}};
      quotient_q  <= {width{1'b0}};
      remainder_q <= {width{1'b0}};
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prem_q      <= prem_d;
      pquo_q      <= pquo_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign div_if.busy        = busy_q;
  assign div_if.done        = done_q;
  assign div_if.quotient    = quotient_q;
  assign div_if.remainder   = remainder_q;
  assign div_if.div_by_zero = dbz_q;

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle unsigned integer divider: radix-2 restoring shift-subtract, one quotient bit per clock.
- Inverse operation to the combinational multiplier in the KGP-RISC ALU datapath.
- Serves the DIV/REM instructions; the control unit stalls on busy and consumes the result on done.

Parameters:
width, 32, operand width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on rising clk edge, accepted only when busy=0.
dividend  input  width  numerator; sampled only at the accept edge.
divisor  input  width  denominator; sampled only at the accept edge.
busy  output  1  high while an accepted division is in progress.
done  output  1  one-cycle pulse; quotient/remainder valid in that cycle.
quotient  output  width  result quotient.
remainder  output  width  result remainder.
div_by_zero  output  1  set with done when the latched divisor was 0.

Behaviour:
- Reset (rst_n=0, async, any state): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; internal registers cleared. An in-flight division is discarded, and no done is produced for it.
- States: IDLE, RUN, DONE.
- Accept: start=1 at an edge while state is IDLE or DONE. All interface values latch at that edge (edge A).
- start while busy=1 is ignored, and operands are not re-sampled.
- Accept with divisor!=0:
  - Next state RUN; count=0; partial remainder R=0; Q=dividend.
- Each RUN edge performs one step:
  - T = {R[width-1:0], Q[width-1]} (width+1 bits).
  - If T >= {1'b0, divisor}: R=T-divisor, shift Q left and insert 1. Otherwise R=T[width-1:0], shift Q left and insert 0.
  - count += 1.
- At the width-th RUN edge (edge A+width):
  - Next state DONE.
  - quotient and remainder load the final Q and R.
  - div_by_zero=0.
- Accept with divisor==0:
  - Next state DONE directly.
  - quotient = all ones; remainder = dividend; div_by_zero=1.
  - Latency is 1 edge.
- DONE lasts exactly one cycle, with done=1.
  - If start=1 at the DONE-exit edge, a new operation is accepted (back-to-back, no bubble).
  - Otherwise the next state is IDLE.
- busy=1 exactly while state==RUN. busy=0 in IDLE and DONE.
- quotient, remainder and div_by_zero hold their last values until the next done-producing edge. They do not change during RUN.
- Latency from accept edge to done-high cycle:
  - width edges (32 for the default) for a normal divide.
  - 1 edge for divide by zero.
  - Throughput is one result per width+1 cycles when start is held high.
- Arithmetic is unsigned. Invariants:
  - quotient*divisor + remainder == dividend.
  - remainder < divisor.
- Comparator and subtractor are width+1 bits wide so the carry-out is never lost. Wrap-around is impossible.
- Edge-case operands:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - dividend=0 gives 0/0 and takes the full width cycles.

Test Plan:
- Basic: width=32; start with 100/7 at edge 0 -> busy=1 during edges 1..31, done=1 in the cycle after edge 32, quotient=14, remainder=2, div_by_zero=0.
- Extremes: 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. 0xFFFFFFFF/0xFFFFFFFF -> 1, 0. 5/0x80000000 -> 0, 5. 0/3 -> 0, 0.
- Divide by zero: 25/0 -> done in the cycle after the accept edge, quotient=0xFFFFFFFF, remainder=25, div_by_zero=1, busy never asserted.
- Handshake protection:
  - At edge 10 of 1000/3, assert start with 9/9 -> ignored.
  - Result is 333 rem 1 at edge 32.
  - Outputs are unchanged during RUN.
- Back-to-back: hold start=1 with 50/5 then 7/2 presented during the DONE cycle -> first done shows 10/0, second done 33 edges later shows 3/1, no IDLE cycle in between.
- Reset mid-operation:
  - Drop rst_n asynchronously during cycle 15 of 77/6 -> busy, done and outputs go to 0 immediately, with no done afterwards.
  - A fresh 77/6 after release yields 12/5.
  - Randomized 10k-vector check of the invariants, including width=8.
